// File: rtl/ov7670_capture.sv
// OV7670 capture front end: synchronizes the camera bus into CLK25,
// assembles RGB565 byte pairs, decimates 2:1 in both axes and emits
// RGB444 write strobes for a downstream frame-buffer address generator.
module ov7670_capture #(
    parameter int H_CAM = 640,
    parameter int V_CAM = 480
) (
    input  logic        CLK25,
    input  logic        reset,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_d,
    output logic        we,
    output logic [11:0] dout,
    output logic        vsync_n,
    output logic        frame_done
);

    localparam logic [1:0] WAIT_FRAME = 2'd0;
    localparam logic [1:0] LINE_IDLE  = 2'd1;
    localparam logic [1:0] BYTE_HI    = 2'd2;
    localparam logic [1:0] BYTE_LO    = 2'd3;

    localparam logic [9:0] COL_MAX = 10'(H_CAM);
    localparam logic [8:0] ROW_MAX = 9'(V_CAM);

    logic       r_pclk_s1, r_pclk_s2, r_pclk_s3;
    logic       r_vsync_s1, r_vsync_s2, r_vsync_s3;
    logic       r_href_s1, r_href_s2, r_href_s3;
    logic [7:0] r_d_s1, r_d_s2;

    logic [1:0]  r_state;
    logic [6:0]  r_hi;      // high byte with R0 dropped: {R4..R1, G5..G3}
    logic [9:0]  r_col;
    logic [8:0]  r_row;
    logic        r_we;
    logic [11:0] r_dout;
    logic        r_frame_done;

    logic w_pclk_edge, w_byte, w_vs_rise, w_vs_fall, w_href_fall, w_in_line, w_keep;

    // s3 stages exist only for edge detection on pclk, vsync and href
    assign w_pclk_edge = r_pclk_s2 & ~r_pclk_s3;
    assign w_byte      = w_pclk_edge & r_href_s2 & ~r_vsync_s2;
    assign w_vs_rise   = r_vsync_s2 & ~r_vsync_s3;
    assign w_vs_fall   = ~r_vsync_s2 & r_vsync_s3;
    assign w_href_fall = ~r_href_s2 & r_href_s3;
    assign w_in_line   = (r_state == BYTE_HI) || (r_state == BYTE_LO);
    // 2:1 decimation in both axes, and nothing past the saturation limits
    assign w_keep      = (r_col < COL_MAX) && (r_row < ROW_MAX) && !r_col[0] && !r_row[0];

    // two-flop synchronizers for the whole camera bus, plus edge-detect stage
    always_ff @(posedge CLK25) begin
        if (reset) begin
            r_pclk_s1  <= 1'b0; r_pclk_s2  <= 1'b0; r_pclk_s3  <= 1'b0;
            r_vsync_s1 <= 1'b0; r_vsync_s2 <= 1'b0; r_vsync_s3 <= 1'b0;
            r_href_s1  <= 1'b0; r_href_s2  <= 1'b0; r_href_s3  <= 1'b0;
            r_d_s1     <= 8'h00; r_d_s2    <= 8'h00;
        end else begin
            r_pclk_s1  <= cam_pclk;  r_pclk_s2  <= r_pclk_s1;  r_pclk_s3  <= r_pclk_s2;
            r_vsync_s1 <= cam_vsync; r_vsync_s2 <= r_vsync_s1; r_vsync_s3 <= r_vsync_s2;
            r_href_s1  <= cam_href;  r_href_s2  <= r_href_s1;  r_href_s3  <= r_href_s2;
            r_d_s1     <= cam_d;     r_d_s2     <= r_d_s1;
        end
    end

    // capture FSM: frame abort beats line end beats byte capture
    always_ff @(posedge CLK25) begin
        if (reset) begin
            r_state      <= WAIT_FRAME;
            r_hi         <= 7'h00;
            r_col        <= 10'd0;
            r_row        <= 9'd0;
            r_we         <= 1'b0;
            r_dout       <= 12'h000;
            r_frame_done <= 1'b0;
        end else begin
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            if (r_state == WAIT_FRAME) begin
                // a partial frame is never trusted; start on a clean vsync end
                r_col <= 10'd0;
                r_row <= 9'd0;
                if (w_vs_fall)
                    r_state <= LINE_IDLE;
            end else if (w_vs_rise) begin
                r_state      <= LINE_IDLE;
                r_col        <= 10'd0;
                r_row        <= 9'd0;
                r_frame_done <= 1'b1;
            end else if (w_href_fall && w_in_line) begin
                // any half pixel is simply forgotten; r_hi is rewritten next line
                r_state <= LINE_IDLE;
                r_col   <= 10'd0;
                if (r_row != ROW_MAX)
                    r_row <= r_row + 9'd1;
            end else if (w_byte) begin
                if (r_state == BYTE_LO) begin
                    if (w_keep) begin
                        r_we   <= 1'b1;
                        r_dout <= {r_hi, r_d_s2[7], r_d_s2[4:1]};
                    end
                    if (r_col != COL_MAX)
                        r_col <= r_col + 10'd1;
                    r_state <= BYTE_HI;
                end else begin
                    r_hi    <= {r_d_s2[7:4], r_d_s2[2:0]};
                    r_state <= BYTE_LO;
                end
            end
        end
    end

    assign we         = r_we;
    assign dout       = r_dout;
    assign frame_done = r_frame_done;
    assign vsync_n    = (r_state != WAIT_FRAME) & ~r_vsync_s2;

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture on a reduced 8x6 camera geometry
// (4x3 = 12 writes per frame) so complete frames stay short.
module tb_ov7670_capture;

    logic        CLK25 = 1'b0;
    logic        reset, cam_pclk, cam_vsync, cam_href;
    logic [7:0]  cam_d;
    logic        we, vsync_n, frame_done;
    logic [11:0] dout;

    int n_chk = 0, n_err = 0;
    int we_cnt = 0, fd_cnt = 0, we_long = 0;
    logic we_d = 1'b0;
    logic [11:0] dq[$];
    int base, fbase;

    always #5 CLK25 = ~CLK25;

    ov7670_capture #(.H_CAM(8), .V_CAM(6)) dut (
        .CLK25(CLK25), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_d(cam_d), .we(we), .dout(dout),
        .vsync_n(vsync_n), .frame_done(frame_done)
    );

    // record every write strobe, its data, and any strobe wider than a cycle
    always @(negedge CLK25) begin
        if (we) begin
            we_cnt++;
            dq.push_back(dout);
            if (we_d) we_long++;
        end
        we_d = we;
        if (frame_done) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK25);
    endtask

    // one byte per two CLK25 cycles: pclk low with data, then pclk high
    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK25);
        cam_d    = b;
        cam_pclk = 1'b0;
        @(negedge CLK25);
        cam_pclk = 1'b1;
    endtask

    task automatic send_pix(input logic [15:0] p);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
    endtask

    task automatic end_line();
        @(negedge CLK25);
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        idle(4);
    endtask

    // pixel (c,r) = {r, c, 8'hC3}
    task automatic send_line(input int npix, input int r);
        logic [3:0] rr, cc;
        cam_href = 1'b1;
        rr = 4'(r);
        for (int c = 0; c < npix; c++) begin
            cc = 4'(c);
            send_pix({rr, cc, 8'hC3});
        end
        end_line();
    endtask

    task automatic end_frame();
        @(negedge CLK25);
        cam_vsync = 1'b1;
        idle(6);
    endtask

    task automatic start_frame();
        @(negedge CLK25);
        cam_vsync = 1'b0;
        idle(6);
    endtask

    initial begin
        reset = 1'b1; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = 8'h00;
        idle(3);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_dout", 32'(dout), 32'h000);
        chk("rst_vsync_n", 32'(vsync_n), 32'd0);
        reset = 1'b0;

        // start-up: pixels before any vsync end are ignored
        send_line(4, 0);
        chk("wait_no_we", 32'(we_cnt), 32'd0);
        chk("wait_vsync_n", 32'(vsync_n), 32'd0);

        // frame A: colours, decimation, partial pixel
        @(negedge CLK25); cam_vsync = 1'b1; idle(4);
        chk("vsn_in_vsync", 32'(vsync_n), 32'd0);
        start_frame();
        chk("vsn_active", 32'(vsync_n), 32'd1);
        cam_href = 1'b1;
        send_pix(16'hF800); send_pix(16'hAAAA); send_pix(16'h07E0); send_pix(16'h5555);
        end_line();
        chk("row0_cnt", 32'(we_cnt), 32'd2);
        chk("red", 32'(dq[0]), 32'hF00);
        chk("green", 32'(dq[1]), 32'h0F0);
        chk("dout_hold", 32'(dout), 32'h0F0);
        cam_href = 1'b1;
        send_byte(8'h12);
        end_line();
        chk("partial_no_we", 32'(we_cnt), 32'd2);
        cam_href = 1'b1;
        send_pix(16'h1234); send_pix(16'h0000); send_pix(16'hFFFF); send_pix(16'h0000);
        end_line();
        chk("row2_cnt", 32'(we_cnt), 32'd4);
        chk("pair_1234", 32'(dq[2]), 32'h14A);
        chk("pair_ffff", 32'(dq[3]), 32'hFFF);
        send_line(4, 3);
        chk("odd_row", 32'(we_cnt), 32'd4);
        chk("no_fd_yet", 32'(fd_cnt), 32'd0);
        end_frame();
        chk("fd_a", 32'(fd_cnt), 32'd1);
        chk("vsn_end", 32'(vsync_n), 32'd0);
        start_frame();

        // frame B: complete 8x6 frame
        base = we_cnt;
        for (int r = 0; r < 6; r++) send_line(8, r);
        chk("full_cnt", 32'(we_cnt - base), 32'd12);
        chk("full_first", 32'(dq[base]), 32'h011);
        chk("full_last", 32'(dq[base + 11]), 32'h4D1);
        end_frame();
        chk("fd_b", 32'(fd_cnt), 32'd2);
        start_frame();

        // frame C: overrun, 10-pixel lines and 8 lines
        base = we_cnt;
        for (int r = 0; r < 8; r++) send_line(10, r);
        chk("over_cnt", 32'(we_cnt - base), 32'd12);
        chk("over_last", 32'(dq[we_cnt - 1]), 32'h4D1);
        end_frame();
        chk("fd_c", 32'(fd_cnt), 32'd3);
        start_frame();

        // frame D: reset mid-frame discards the rest of it
        send_line(4, 0);
        cam_href = 1'b1;
        send_byte(8'h22);
        reset = 1'b1;
        idle(2);
        chk("mid_rst_dout", 32'(dout), 32'h000);
        reset = 1'b0;
        send_byte(8'h33);
        end_line();
        base = we_cnt;
        for (int r = 2; r < 6; r++) send_line(4, r);
        chk("after_rst_no_we", 32'(we_cnt - base), 32'd0);
        fbase = fd_cnt;
        end_frame();
        chk("no_fd_in_wait", 32'(fd_cnt - fbase), 32'd0);
        start_frame();
        base = we_cnt;
        send_line(4, 0);
        chk("resume_cnt", 32'(we_cnt - base), 32'd2);
        chk("resume_first", 32'(dq[base]), 32'h011);

        chk("we_one_cycle", 32'(we_long), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ov7670_capture.md
OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 The block SHALL use parameter H_CAM, default 640, meaning camera pixels per line.
REQ-002 The block SHALL use parameter V_CAM, default 480, meaning camera lines per frame.
REQ-003 The block SHALL have port CLK25, input, 1, meaning the single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port cam_pclk, input, 1, meaning the camera pixel clock, asynchronous and sampled as data.
REQ-006 The block SHALL have port cam_vsync, input, 1, meaning camera frame sync (high = vertical blanking), asynchronous.
REQ-007 The block SHALL have port cam_href, input, 1, meaning camera line-valid, asynchronous.
REQ-008 The block SHALL have port cam_d, input, 8, meaning camera data byte, RGB565 with the high byte first.
REQ-009 The block SHALL have port we, output, 1, meaning a one-cycle pixel-write strobe that drives the downstream address generator enable.
REQ-010 The block SHALL have port dout, output, 12, meaning RGB444 pixel data, valid when we=1.
REQ-011 The block SHALL have port vsync_n, output, 1, meaning the frame restart to the address generator (0 = reset address).
REQ-012 The block SHALL have port frame_done, output, 1, meaning a one-cycle pulse at the end of each captured frame.

Function
REQ-013 cam_pclk, cam_vsync, cam_href and cam_d SHALL each pass through two synchronizer flops (s1, s2), with a third pclk flop s3.
REQ-014 A pixel-clock edge SHALL be defined as pclk_s2=1 and pclk_s3=0; bytes are sampled from cam_d s2 on edge cycles with href_s2=1.
REQ-015 The FSM SHALL have four states:
- WAIT_FRAME: after reset; leaves on the vsync_s2 falling edge, then goes to LINE_IDLE.
- LINE_IDLE
- BYTE_HI: first byte of a pixel.
- BYTE_LO: second byte of a pixel.
REQ-016 In LINE_IDLE, an edge with href_s2=1 SHALL latch the high byte and enter BYTE_LO; the next qualifying edge SHALL complete the pixel and return to BYTE_HI.
REQ-017 When href_s2 falls in BYTE_HI or BYTE_LO, the FSM SHALL enter LINE_IDLE, drop any half-assembled byte, clear col, and increment row.
REQ-018 Column counter col (10 bits) SHALL increment per completed pixel; row counter row (9 bits) SHALL increment per line; both SHALL saturate at H_CAM and V_CAM.
REQ-019 Decimation SHALL keep only pixels with col even, row even, col<H_CAM and row<V_CAM, giving at most 320x240 = 76800 writes per frame.
REQ-020 For kept pixels, with hi = {R4..R0,G5..G3} and lo = {G2..G0,B4..B0}, dout SHALL be {R[4:1],G[5:2],B[4:1]}.
REQ-021 we SHALL assert for exactly one CLK25 cycle, registered on the cycle after the completing edge, with dout stable that cycle; dout SHALL hold its value otherwise.
REQ-022 vsync_n SHALL equal the inverse of vsync_s2; it SHALL also be held at 0 in WAIT_FRAME.
REQ-023 A rising edge of vsync_s2 in any non-WAIT_FRAME state SHALL abort the frame:
- FSM goes to LINE_IDLE.
- row and col clear.
- frame_done pulses for one cycle the following cycle.
REQ-024 Pixels arriving while vsync_s2=1, or beyond the saturation limits, SHALL be ignored (no we).
REQ-025 Simultaneous href fall and vsync rise SHALL be handled as vsync (REQ-023) only; row SHALL NOT be incremented.

Reset
REQ-026 While reset=1, and on the cycle after it:
- we=0, frame_done=0, dout=12'h000, vsync_n=0.
- FSM in WAIT_FRAME.
- col=0, row=0.
- All synchronizer flops = 0.
REQ-027 Reset asserted mid-frame SHALL discard the frame; capture SHALL resume only after the next vsync_s2 falling edge.

Verification
REQ-028 Full frame: 640x480 RGB565 frame with pclk = CLK25/2 -> exactly 76800 we pulses, then one frame_done; vsync_n low only during camera vsync.
REQ-029 Color: bytes 8'hF8, 8'h00 at col 0 / row 0 -> dout=12'hF00 with we=1 for one cycle; bytes 8'h07, 8'hE0 -> dout=12'h0F0.
REQ-030 Decimation: single line of 4 pixels with values A, B, C, D -> we on A and C only; row 1 produces no we.
REQ-031 Partial pixel: href falls after one byte -> no we; next line starts with col=0 and correct byte pairing.
REQ-032 Start-up: reset released mid-frame -> no we until the vsync falling edge; the first we is pixel (0,0) of the next frame.
REQ-033 Overrun: line of 700 pixels or frame of 500 lines -> we count still capped at 320 per line and 76800 per frame.
